// File: rtl/serial_bus_arbiter.sv
// Two-master serial bus arbiter: round-robin grants, split-transaction parking,
// and forced grant revocation after TIMEOUT cycles with a per-master lockout.
module serial_bus_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_breq,
  input  logic m2_breq,
  output logic m1_bgrant,
  output logic m2_bgrant,
  output logic msel,
  output logic bus_owned,
  input  logic split_req,
  input  logic split_done,
  output logic split_pend,
  output logic timeout_err
);

  typedef enum logic {IDLE, OWN} state_e;

  // Master encoding for owner/last/split_mst/prio_mst: 0 = master 1, 1 = master 2
  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             split_mst_q, split_mst_d;
  logic             split_pend_q, split_pend_d;
  logic             prio_q, prio_d;
  logic             prio_mst_q, prio_mst_d;
  logic             lock1_q, lock1_d;
  logic             lock2_q, lock2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m1_bgrant_q, m1_bgrant_d;
  logic             m2_bgrant_q, m2_bgrant_d;
  logic             bus_owned_q, bus_owned_d;
  logic             timeout_err_q, timeout_err_d;

  logic pend_eff, prio_eff, prio_mst_eff;
  logic elig1, elig2, win, owner_breq, timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      split_mst_q   <= 1'b0;
      split_pend_q  <= 1'b0;
      prio_q        <= 1'b0;
      prio_mst_q    <= 1'b0;
      lock1_q       <= 1'b0;
      lock2_q       <= 1'b0;
      cnt_q         <= '0;
      m1_bgrant_q   <= 1'b0;
      m2_bgrant_q   <= 1'b0;
      bus_owned_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      split_mst_q   <= split_mst_d;
      split_pend_q  <= split_pend_d;
      prio_q        <= prio_d;
      prio_mst_q    <= prio_mst_d;
      lock1_q       <= lock1_d;
      lock2_q       <= lock2_d;
      cnt_q         <= cnt_d;
      m1_bgrant_q   <= m1_bgrant_d;
      m2_bgrant_q   <= m2_bgrant_d;
      bus_owned_q   <= bus_owned_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    // split_done is applied before anything else looks at the parked master
    pend_eff     = split_pend_q & ~split_done;
    prio_eff     = prio_q | (split_pend_q & split_done);
    prio_mst_eff = (split_pend_q & split_done) ? split_mst_q : prio_mst_q;

    elig1 = m1_breq & ~lock1_q & ~(pend_eff & ~split_mst_q);
    elig2 = m2_breq & ~lock2_q & ~(pend_eff & split_mst_q);

    if (prio_eff && (prio_mst_eff ? elig2 : elig1)) begin
      win = prio_mst_eff;
    end else if (elig1 && elig2) begin
      win = ~last_q;
    end else begin
      win = ~elig1;
    end

    owner_breq  = owner_q ? m2_breq : m1_breq;
    timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    split_mst_d   = split_mst_q;
    split_pend_d  = pend_eff;
    prio_d        = prio_eff;
    prio_mst_d    = prio_mst_eff;
    lock1_d       = lock1_q & m1_breq;
    lock2_d       = lock2_q & m2_breq;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (elig1 || elig2) begin
          state_d = OWN;
          owner_d = win;
          last_d  = win;
          if (prio_eff && (win == prio_mst_eff)) begin
            prio_d = 1'b0;
          end
        end
      end
      OWN: begin
        cnt_d = timeout_hit ? cnt_q : cnt_q + CNT_W'(1);
        // Release causes in priority order: split, timeout, normal release
        if (split_req && !pend_eff) begin
          state_d      = IDLE;
          split_pend_d = 1'b1;
          split_mst_d  = owner_q;
        end else if (timeout_hit) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
          if (owner_q) begin
            lock2_d = 1'b1;
          end else begin
            lock1_d = 1'b1;
          end
        end else if (!owner_breq) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    m1_bgrant_d = (state_d == OWN) & ~owner_d;
    m2_bgrant_d = (state_d == OWN) & owner_d;
    bus_owned_d = (state_d == OWN);
  end

  assign m1_bgrant   = m1_bgrant_q;
  assign m2_bgrant   = m2_bgrant_q;
  assign bus_owned   = bus_owned_q;
  assign msel        = owner_q;
  assign split_pend  = split_pend_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: vector table, directed corner sequences and
// random traffic against a cycle-level reference model.
module tb_serial_bus_arbiter;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic m1_breq, m2_breq, split_req, split_done;
  logic m1_bgrant, m2_bgrant, msel, bus_owned, split_pend, timeout_err;

  int total = 0;
  int bad   = 0;

  serial_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m1_breq(m1_breq), .m2_breq(m2_breq),
    .m1_bgrant(m1_bgrant), .m2_bgrant(m2_bgrant),
    .msel(msel), .bus_owned(bus_owned),
    .split_req(split_req), .split_done(split_done),
    .split_pend(split_pend), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, how long it has held it, who is parked
  bit own;
  int own_m;
  int last_m;
  bit park;
  int park_m;
  bit pri;
  int pri_m;
  bit lk[2];
  int held;
  bit merr;

  typedef struct packed {
    bit r1, r2, sr, sd;
    bit g1, g2, ms, pend, err;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = 0; own_m = 0; last_m = 1; park = 0; park_m = 0;
    pri = 0; pri_m = 0; lk[0] = 0; lk[1] = 0; held = 0; merr = 0;
  endtask

  task automatic model_step(input bit r1, input bit r2, input bit sr, input bit sd);
    bit rq[2];
    bit want[2];
    bit set_lk[2];
    int pick;
    rq[0] = r1; rq[1] = r2; set_lk[0] = 0; set_lk[1] = 0; merr = 0;
    if (sd && park) begin
      park = 0; pri = 1; pri_m = park_m;
    end
    for (int k = 0; k < 2; k++) want[k] = rq[k] && !lk[k] && !(park && park_m == k);
    if (!own) begin
      pick = -1;
      if (pri && want[pri_m]) pick = pri_m;
      else if (want[0] && want[1]) pick = 1 - last_m;
      else if (want[0]) pick = 0;
      else if (want[1]) pick = 1;
      if (pick >= 0) begin
        own = 1; own_m = pick; last_m = pick; held = 1;
        if (pri && pick == pri_m) pri = 0;
      end
    end else begin
      if (sr && !park) begin
        own = 0; park = 1; park_m = own_m;
      end else if (held == int'(TO)) begin
        own = 0; merr = 1; set_lk[own_m] = 1;
      end else if (!rq[own_m]) begin
        own = 0;
      end else begin
        held++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (!rq[k]) lk[k] = 0;
      if (set_lk[k]) lk[k] = 1;
    end
  endtask

  task automatic check_model();
    chk("mdl_g1", m1_bgrant, own && own_m == 0);
    chk("mdl_g2", m2_bgrant, own && own_m == 1);
    chk("mdl_owned", bus_owned, own);
    chk("mdl_msel", msel, own_m == 1);
    chk("mdl_pend", split_pend, park);
    chk("mdl_err", timeout_err, merr);
  endtask

  task automatic tick(input bit r1, input bit r2, input bit sr, input bit sd);
    m1_breq = r1; m2_breq = r2; split_req = sr; split_done = sd;
    @(posedge clk);
    model_step(r1, r2, sr, sd);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m1_breq = 0; m2_breq = 0; split_req = 0; split_done = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_g1", m1_bgrant, 1'b0);
    chk("rst_g2", m2_bgrant, 1'b0);
    chk("rst_owned", bus_owned, 1'b0);
    chk("rst_msel", msel, 1'b0);
    chk("rst_pend", split_pend, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
  endtask

  initial begin
    vec_t v;
    int h1, h2, nstart, prev_start;
    bit pg1, pg2;
    bit r1, r2;

    // {r1 r2 sr sd} -> {g1 g2 msel pend err} after the edge
    tbl[0] = 9'b1100_10000;
    tbl[1] = 9'b1100_10000;
    tbl[2] = 9'b1100_10000;
    tbl[3] = 9'b1100_10000;
    tbl[4] = 9'b1100_10000;
    tbl[5] = 9'b0100_00000;
    tbl[6] = 9'b0100_01100;
    tbl[7] = 9'b0100_01100;
    tbl[8] = 9'b0000_00100;
    tbl[9] = 9'b0000_00100;

    do_reset();
    for (int i = 0; i < 10; i++) begin
      v = tbl[i];
      tick(v.r1, v.r2, v.sr, v.sd);
      chk("tbl_g1", m1_bgrant, v.g1);
      chk("tbl_g2", m2_bgrant, v.g2);
      chk("tbl_msel", msel, v.ms);
      chk("tbl_pend", split_pend, v.pend);
      chk("tbl_err", timeout_err, v.err);
      chk("tbl_owned", bus_owned, v.g1 | v.g2);
    end

    // Continuous requests, 3-cycle transactions: owners must alternate
    do_reset();
    h1 = 0; h2 = 0; nstart = 0; prev_start = 1; pg1 = 0; pg2 = 0;
    for (int i = 0; i < 24; i++) begin
      tick(h1 < 3, h2 < 3, 1'b0, 1'b0);
      if (m1_bgrant && !pg1) begin
        chk("alt_m1_after_m2", prev_start == 1, 1'b1);
        prev_start = 0; nstart++;
      end
      if (m2_bgrant && !pg2) begin
        chk("alt_m2_after_m1", prev_start == 0, 1'b1);
        prev_start = 1; nstart++;
      end
      pg1 = m1_bgrant; pg2 = m2_bgrant;
      h1 = m1_bgrant ? h1 + 1 : 0;
      h2 = m2_bgrant ? h2 + 1 : 0;
    end
    chk("alt_count", nstart >= 5, 1'b1);

    // Split, ignored second split, split_done while m2 owns
    do_reset();
    tick(1, 1, 0, 0); chk("sp_g1", m1_bgrant, 1'b1);
    tick(1, 1, 1, 0); chk("sp_g1_drop", m1_bgrant, 1'b0); chk("sp_pend", split_pend, 1'b1);
    tick(1, 1, 0, 0); chk("sp_g2", m2_bgrant, 1'b1); chk("sp_msel", msel, 1'b1);
    tick(1, 1, 1, 0); chk("sp2_keep_g2", m2_bgrant, 1'b1); chk("sp2_pend", split_pend, 1'b1);
    tick(1, 0, 0, 0); chk("sp_rel_g2", m2_bgrant, 1'b0);
    tick(1, 0, 0, 0); chk("sp_m1_parked", m1_bgrant, 1'b0);
    tick(1, 1, 0, 0); chk("sp_g2_again", m2_bgrant, 1'b1);
    tick(1, 1, 0, 1); chk("spd_g2", m2_bgrant, 1'b1); chk("spd_pend", split_pend, 1'b0);
    tick(1, 0, 0, 0); chk("spd_rel", bus_owned, 1'b0);
    tick(1, 1, 0, 0); chk("spd_g1", m1_bgrant, 1'b1);

    // Released master beats round-robin (last was m1 itself)
    do_reset();
    tick(1, 0, 0, 0); chk("pr_g1", m1_bgrant, 1'b1);
    tick(1, 0, 1, 0); chk("pr_pend", split_pend, 1'b1);
    tick(0, 0, 0, 0); chk("pr_idle", bus_owned, 1'b0);
    tick(0, 0, 0, 1); chk("pr_done", split_pend, 1'b0);
    tick(1, 1, 0, 0); chk("pr_g1_wins", m1_bgrant, 1'b1);

    // split_done and split_req in the same cycle
    do_reset();
    tick(1, 1, 0, 0);
    tick(1, 1, 1, 0);
    tick(1, 1, 0, 0); chk("sd_g2", m2_bgrant, 1'b1);
    tick(1, 1, 1, 1); chk("sd_g2_drop", m2_bgrant, 1'b0); chk("sd_pend", split_pend, 1'b1);
    tick(1, 1, 0, 0); chk("sd_g1", m1_bgrant, 1'b1); chk("sd_msel", msel, 1'b0);
    tick(0, 1, 0, 0); chk("sd_rel", bus_owned, 1'b0);
    tick(0, 1, 0, 0); chk("sd_m2_parked", m2_bgrant, 1'b0);

    // Timeout: exactly TO grant cycles, error pulse, lockout until breq toggles
    do_reset();
    for (int i = 0; i < int'(TO); i++) begin
      tick(1, 0, 0, 0); chk("to_hold", m1_bgrant, 1'b1);
    end
    tick(1, 0, 0, 0); chk("to_revoke", m1_bgrant, 1'b0); chk("to_err", timeout_err, 1'b1);
    tick(1, 1, 0, 0); chk("to_err_pulse", timeout_err, 1'b0); chk("to_g2", m2_bgrant, 1'b1);
    tick(1, 0, 0, 0); chk("to_rel2", bus_owned, 1'b0);
    tick(1, 0, 0, 0); chk("to_locked", m1_bgrant, 1'b0);
    tick(0, 0, 0, 0); chk("to_idle", bus_owned, 1'b0);
    tick(1, 0, 0, 0); chk("to_unlock", m1_bgrant, 1'b1);

    // Asynchronous reset in the middle of a grant with a parked split
    do_reset();
    tick(1, 1, 0, 0);
    tick(1, 1, 1, 0);
    tick(1, 1, 0, 0); chk("ar_g2", m2_bgrant, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_g2_drop", m2_bgrant, 1'b0);
    chk("ar_owned", bus_owned, 1'b0);
    chk("ar_pend", split_pend, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick(1, 1, 0, 0); chk("ar_tie_m1", m1_bgrant, 1'b1);

    // Random traffic against the model
    do_reset();
    r1 = 0; r2 = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) r1 = ~r1;
      if ($urandom_range(7) == 0) r2 = ~r2;
      tick(r1, r2, $urandom_range(15) == 0, $urandom_range(9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
